// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word fall-through output; registered read output otherwise.
module fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       WREN,
  input  logic                       RDEN,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ov_q, un_q, wr, rd;
  always_comb begin
    wr    = WREN && !full;
    rd    = RDEN && !empty;
    wp_d  = wr ? wp_q + AW'(1) : wp_q;
    rp_d  = rd ? rp_q + AW'(1) : rp_q;
    cnt_d = (wr && !rd) ? cnt_q + CW'(1) : (rd && !wr) ? cnt_q - CW'(1) : cnt_q;
  end
  assign full         = cnt_q == CW'(DEPTH);
  assign empty        = cnt_q == '0;
  assign almost_full  = cnt_q >= CW'(AF_LEVEL);
  assign almost_empty = cnt_q <= CW'(AE_LEVEL);
  assign count        = cnt_q;
  assign overflow     = ov_q;
  assign underflow    = un_q;
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (wr) mem[wp_q] <= data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      un_q  <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ov_q  <= WREN && full;
      un_q  <= RDEN && empty;
    end
`ifdef FIFO_FWFT_EN
  assign data_out = mem[rp_q];
`else
  logic [DATA_W-1:0] dout_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) dout_q <= '0;
    else if (rd) dout_q <= mem[rp_q];
  assign data_out = dout_q;
`endif
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO: configurable width, depth, and almost-full/almost-empty thresholds, plus a fill-level count and overflow/underflow error pulses. It is the general-purpose buffer between producer and consumer logic in the same clock domain. It owns its storage array internally; no separate memory module is instantiated. Read mode is either registered-output (default) or first-word fall-through, selected at compile time.

## Interface
- DATA_W, 8, word width in bits.
- DEPTH, 8, number of entries; power of two, ≥ 2.
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous and active-high.
- WREN  in  1  write request.
- RDEN  in  1  read request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH+1)  current number of stored words.
- overflow  out  1  one-cycle pulse after a refused write.
- underflow  out  1  one-cycle pulse after a refused read.

## Operation
- **Pointers.**
  - Write and read pointers are $clog2(DEPTH) bits wide.
  - Each increments by 1 per accepted operation and wraps DEPTH-1 → 0 naturally.
  - count is a separate register; it is not derived from the pointers.
- **Acceptance.**
  - Write accepted = WREN && !full.
  - Read accepted = RDEN && !empty.
  - Both are evaluated on the pre-edge state.
- **Count update.**
  - +1 for a write only.
  - −1 for a read only.
  - Unchanged when both are accepted, or when neither is.
- **Simultaneous WREN and RDEN.**
  - Neither full nor empty: both accepted; count is unchanged.
  - full: read accepted, write refused; overflow pulses; count becomes DEPTH-1.
  - empty: write accepted, read refused; underflow pulses; count becomes 1. A word cannot be read in the cycle it is written.
- **Error pulses.**
  - overflow = registered (WREN && full).
  - underflow = registered (RDEN && empty).
  - Each is high for exactly the one cycle after the offending edge.
  - A refused access never changes pointers, count, memory, or data_out.
- **Status flags.** full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- **Reset** (applies immediately, including mid-operation):
  - Pointers and count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, data_out = 0.
  - Memory contents are not cleared; they are unreachable until rewritten.

## Timing
- Write latency: a word written at edge N is readable from edge N+1 onward (empty falls after edge N).
- Default read mode:
  - data_out is registered.
  - A read accepted at edge N presents its word on data_out after edge N.
  - data_out holds its value until the next accepted read.
- Flags and count change only after rising edges (or on reset assertion); they are stable within a cycle.
- Throughput is one write and one read per cycle sustained, when the FIFO is neither full nor empty.

## Configuration
- Macro: FIFO_FWFT_EN.
- **Defined (first-word fall-through):**
  - data_out combinationally shows the word at the read pointer whenever empty == 0.
  - RDEN acts as an acknowledge; the next word, if any, appears after the accepting edge.
  - data_out is don't-care while empty == 1.
  - The data_out register is removed; all other behaviour is unchanged.
- **Undefined:** registered-output mode, as described in Timing.

## Test plan
All scenarios use DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
- **Reset:** assert rst mid-traffic with count=5.
  - Immediately: count=0, empty=1, almost_empty=1, full=0, data_out=0.
  - After release, the first read is refused with an underflow pulse.
- **Fill/drain:** write 0x10..0x17 on 8 consecutive cycles.
  - almost_full rises when count reaches 6; full rises after the 8th write.
  - A 9th WREN gives overflow=1 for one cycle and count stays 8.
  - Reading 8 words returns 0x10..0x17 in order; empty=1 at the end.
- **Wrap-around:** write 6, read 6, then write 6 more (0xA0..0xA5).
  - Reads return 0xA0..0xA5 in order; pointers have wrapped past 7.
- **Simultaneous when full:** full FIFO, WREN=RDEN=1 for one cycle.
  - Read is accepted, write refused; overflow=1; count=7.
- **Simultaneous when empty, then streaming:**
  - Empty FIFO, WREN=RDEN=1 with data 0x55: count=1, underflow=1.
  - Then 20 cycles of WREN=RDEN=1 with incrementing data: count stays 1 and the output sequence is in order.
- **FWFT build:**
  - Write 0x3C into an empty FIFO: data_out=0x3C before any RDEN.
  - Pulse RDEN: empty=1 after that edge.
